ins_line_fill: RTL

- Fill engine that writes the instruction line buffer consumed by instruction fetch.
- On a fetch request (read_enable) it reads a block of quadwords from local store over a request/grant/response interface.
- It unpacks each quadword into four 32-bit instruction words and writes them into the 256-word ins_cache array.
- It publishes a valid-word count so fetch can stall at any pc >= fill_count.

---
 rtl/ins_line_fill.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/ins_line_fill.sv
// ins_line_fill
//   Fill engine for the instruction line buffer read by instruction fetch.
//   A fetch request (read_enable) or a branch redirect (flush) starts a fill
//   of DEPTH/4 quadwords from local store, starting at base_addr. Each
//   quadword is split into four 32-bit instructions and written into
//   ins_cache. fill_count tells fetch how many words are valid so far.
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   read_enable       fill request from fetch (only honoured when idle)
//   flush             abort and restart the fill at base_addr
//   base_addr         quadword address of the block start
//   ls_req/ls_addr    local store read request and its quadword address
//   ls_gnt            request accepted this cycle
//   ls_rvalid/ls_rdata in-order read response; ls_rdata[0:31] is the first word
//   ins_cache         DEPTH-word instruction buffer
//   fill_count        number of valid words (0..DEPTH)
//   busy              engine is not idle
//   fill_done         one-cycle pulse after the last beat is written
//   protocol_err      sticky: a response arrived with nothing outstanding
module ins_line_fill #(
    parameter int DEPTH   = 256,
    parameter int LS_AW   = 14,
    parameter int MAX_OUT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             read_enable,
    input  logic             flush,
    input  logic [LS_AW-1:0] base_addr,
    output logic             ls_req,
    output logic [LS_AW-1:0] ls_addr,
    input  logic             ls_gnt,
    input  logic             ls_rvalid,
    input  logic [0:127]     ls_rdata,
    output logic [31:0]      ins_cache [0:DEPTH-1],
    output logic [8:0]       fill_count,
    output logic             busy,
    output logic             fill_done,
    output logic             protocol_err
);

    localparam int BEATS = DEPTH / 4;
    localparam int CW    = $clog2(BEATS + 1);   // holds 0..BEATS
    localparam int RW    = $clog2(BEATS);       // beat index into the buffer
    localparam int OW    = $clog2(MAX_OUT + 1); // holds 0..MAX_OUT

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN
    } state_t;

    state_t           state, state_next;
    logic [LS_AW-1:0] base_q;
    logic [CW-1:0]    issued;
    logic [CW-1:0]    received;
    logic [OW-1:0]    outstanding, out_next;
    logic             restart_q;

    logic resp_ok;     // response that matches an outstanding request
    logic grant;
    logic beat_write;  // response accepted into the buffer
    logic last_beat;
    logic load;        // latch base_addr and restart the counters

    assign busy = (state != IDLE);

    // NOTE: every signal driven here gets a value on every path (state_next
    // starts from the current state), so no latches are inferred.
    always_comb begin
        resp_ok    = ls_rvalid && (outstanding != '0);
        // restart_q holds the request off for one cycle after a flush that
        // restarts FILL directly, so the new block never overlaps the old.
        ls_req     = (state == FILL) && !restart_q
                     && (issued < CW'(BEATS)) && (outstanding < OW'(MAX_OUT));
        ls_addr    = base_q + LS_AW'(issued);
        grant      = ls_req && ls_gnt;
        // A grant is only possible below MAX_OUT, so this never overflows.
        out_next   = outstanding + OW'(grant) - OW'(resp_ok);
        beat_write = (state == FILL) && !flush && resp_ok;
        last_beat  = beat_write && (received == CW'(BEATS - 1));
        load       = flush || ((state == IDLE) && read_enable);

        state_next = state;
        case (state)
            IDLE: begin
                if (flush || read_enable) state_next = FILL;
            end
            FILL: begin
                if (flush)          state_next = (out_next != '0) ? DRAIN : FILL;
                else if (last_beat) state_next = IDLE;
            end
            DRAIN: begin
                // Stale responses are discarded; refill once all have returned.
                if (!flush && (out_next == '0)) state_next = FILL;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values of the others, as real flops do.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            base_q       <= '0;
            issued       <= '0;
            received     <= '0;
            outstanding  <= '0;
            restart_q    <= 1'b0;
            fill_count   <= '0;
            fill_done    <= 1'b0;
            protocol_err <= 1'b0;
            // NOTE: the buffer is cleared on reset because fetch may look at
            // it before the first fill; this costs a reset path on every word.
            for (int i = 0; i < DEPTH; i++) ins_cache[i] <= '0;
        end else begin
            state       <= state_next;
            outstanding <= out_next;
            restart_q   <= (state == FILL) && flush;
            fill_done   <= last_beat;
            if (ls_rvalid && (outstanding == '0)) protocol_err <= 1'b1;

            if (load) begin
                base_q     <= base_addr;
                issued     <= '0;
                received   <= '0;
                fill_count <= '0;
            end else begin
                if (grant) issued <= issued + CW'(1);
                if (beat_write) begin
                    received   <= received + CW'(1);
                    fill_count <= fill_count + 9'd4;
                    for (int j = 0; j < 4; j++)
                        ins_cache[{received[RW-1:0], 2'(j)}] <= ls_rdata[32*j +: 32];
                end
            end
        end
    end

endmodule
